// File: rtl/conv1_calc_if.sv
// Bundle of window, kernel-load and result signals for the first-layer 5x5 convolution.
// Latency: none, wiring only.
// Backpressure: none; master is the window/kernel source, slave is conv1_calc.
interface conv1_calc_if #(
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int OUT_BITS    = 12
);
    // Window pixels, row-major, index 0 = top-left.
    logic [24:0][DATA_BITS-1:0]    data_in;
    logic                          valid_in;

    // Serial kernel/bias load: 25 weights then the bias.
    logic                          w_load_start;
    logic                          w_load_en;
    logic signed [WEIGHT_BITS-1:0] w_data;
    logic                          w_ready;

    // Feature-map sample to the pooling stage.
    logic signed [OUT_BITS-1:0]    data_out;
    logic                          valid_out;

    modport master (
        output data_in, valid_in, w_load_start, w_load_en, w_data,
        input  w_ready, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, w_load_start, w_load_en, w_data,
        output w_ready, data_out, valid_out
    );
endinterface

// File: rtl/conv1_calc.sv
// 5x5 convolution of one pixel window per cycle with a serially loaded kernel, bias, round, shift, saturate.
// Latency: 4 register stages (products, row sums, total+bias+round, shift/saturate); one window per cycle.
// Backpressure: none; windows arriving without a loaded kernel are dropped, a reload flushes in-flight results.
// Optional: define CONV1_CALC_RELU_EN to clamp negative results to zero.
module conv1_calc #(
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 22,
    parameter int FRAC_BITS   = 4,
    parameter int OUT_BITS    = 12
) (
    input  logic         clk,
    input  logic         rst,
    conv1_calc_if.slave  bus
);
    localparam int NTAPS  = 25;
    localparam int PROD_W = DATA_BITS + WEIGHT_BITS + 1;

    localparam logic [4:0] BIAS_IDX = 5'(NTAPS);

    // Half an output LSB, added before the floor shift so results round half up.
    localparam logic signed [ACC_BITS-1:0] RND = ACC_BITS'(1) << (FRAC_BITS - 1);

    localparam logic signed [OUT_BITS-1:0] RES_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [OUT_BITS-1:0] RES_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADING,
        S_READY
    } load_state_t;

    load_state_t                   state;
    logic [4:0]                    w_idx;
    logic                          w_ready_q;
    logic signed [WEIGHT_BITS-1:0] weight [NTAPS];
    logic signed [WEIGHT_BITS-1:0] bias;

    logic signed [PROD_W-1:0]      prod [NTAPS];
    logic signed [ACC_BITS-1:0]    row  [5];
    logic signed [ACC_BITS-1:0]    acc;
    logic                          v1, v2, v3;
    logic                          valid_out_q;
    logic signed [OUT_BITS-1:0]    data_out_q;

    logic                          accept;
    logic signed [ACC_BITS-1:0]    shifted;
    logic signed [OUT_BITS-1:0]    res;

    assign accept        = bus.valid_in & w_ready_q;
    assign bus.w_ready   = w_ready_q;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;

    // Kernel load FSM: a start pulse always restarts at index 0; beats outside LOADING are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            w_idx     <= '0;
            w_ready_q <= 1'b0;
            bias      <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                weight[i] <= '0;
            end
        end else if (bus.w_load_start) begin
            state     <= S_LOADING;
            w_idx     <= '0;
            w_ready_q <= 1'b0;
        end else if (state == S_LOADING && bus.w_load_en) begin
            if (w_idx == BIAS_IDX) begin
                bias      <= bus.w_data;
                state     <= S_READY;
                w_ready_q <= 1'b1;
            end else begin
                weight[w_idx] <= bus.w_data;
            end
            w_idx <= w_idx + 5'd1;
        end
    end

    // Stage valids and output register; a reload drops everything in flight so no result mixes kernels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else if (bus.w_load_start) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            v1          <= accept;
            v2          <= v1;
            v3          <= v2;
            valid_out_q <= v3;
            if (v3) begin
                data_out_q <= res;
            end
        end
    end

    // Datapath registers: products, row sums, then total with bias and rounding constant.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTAPS; i++) begin
            prod[i] <= PROD_W'($signed({1'b0, bus.data_in[i]})) * PROD_W'(weight[i]);
        end
        for (int r = 0; r < 5; r++) begin
            row[r] <= ACC_BITS'(prod[5*r])   + ACC_BITS'(prod[5*r+1]) + ACC_BITS'(prod[5*r+2])
                    + ACC_BITS'(prod[5*r+3]) + ACC_BITS'(prod[5*r+4]);
        end
        acc <= row[0] + row[1] + row[2] + row[3] + row[4]
             + (ACC_BITS'(bias) <<< FRAC_BITS) + RND;
    end

    // Drop fractional bits (floor after rounding), saturate to the output range, optionally rectify.
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > ACC_BITS'(RES_MAX)) begin
            res = RES_MAX;
        end else if (shifted < ACC_BITS'(RES_MIN)) begin
            res = RES_MIN;
        end else begin
            res = shifted[OUT_BITS-1:0];
        end
`ifdef CONV1_CALC_RELU_EN
        if (res[OUT_BITS-1]) begin
            res = '0;
        end
`else
`endif
    end
endmodule

// File: tb/tb_conv1_calc.sv
// Bench for conv1_calc: directed kernel/window scenarios plus randomized streams against an arithmetic model.
// Latency: expected results are held in a 4-deep delay line and compared every cycle.
// Backpressure: none; the model tracks kernel readiness and reload flushes itself.
module tb_conv1_calc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    conv1_calc_if #(.DATA_BITS(8), .WEIGHT_BITS(8), .OUT_BITS(12)) bus ();

    conv1_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int d;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t dq[$];
    int   kw[25];
    int   kb;
    int   m_cnt;
    bit   m_ready;
    int   last_out;
    logic [7:0] pix [25];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: full dot product plus scaled bias, add half LSB, floor-divide by 16, clamp.
    function automatic int model_out();
        int s;
        int q;
        s = kb * 16 + 8;
        for (int i = 0; i < 25; i++) begin
            s += int'(pix[i]) * kw[i];
        end
        if (s >= 0) q = s / 16;
        else        q = -((-s + 15) / 16);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
`ifdef CONV1_CALC_RELU_EN
        if (q < 0) q = 0;
`else
`endif
        return q;
    endfunction

    task automatic model_reset();
        exp_t z;
        z.v = 1'b0;
        z.d = 0;
        dq.delete();
        for (int i = 0; i < 3; i++) dq.push_back(z);
        m_ready  = 1'b0;
        m_cnt    = 26;
        last_out = 0;
    endtask

    // One clock: drive inputs, update the model, tick, compare outputs.
    task automatic step(input bit vin, input bit st, input bit en, input int wd);
        exp_t e;
        exp_t o;
        e.v = vin && m_ready && !st;
        e.d = e.v ? model_out() : 0;
        if (st) begin
            foreach (dq[i]) dq[i].v = 1'b0;
            m_cnt   = 0;
            m_ready = 1'b0;
        end else if (en && m_cnt <= 25) begin
            if (m_cnt < 25) kw[m_cnt] = wd;
            else begin
                kb      = wd;
                m_ready = 1'b1;
            end
            m_cnt++;
        end
        dq.push_back(e);
        bus.valid_in     = vin;
        bus.w_load_start = st;
        bus.w_load_en    = en;
        bus.w_data       = 8'(wd);
        for (int i = 0; i < 25; i++) bus.data_in[i] = pix[i];
        @(posedge clk);
        #1;
        o = dq.pop_front();
        if (o.v) last_out = o.d;
        check("valid_out", bus.valid_out, o.v);
        check("data_out", bus.data_out, last_out);
        check("w_ready", bus.w_ready, m_ready);
    endtask

    task automatic load(input int w[25], input int b, input bit vin);
        step(vin, 1'b1, 1'b0, 0);
        for (int i = 0; i < 25; i++) step(vin, 1'b0, 1'b1, w[i]);
        step(vin, 1'b0, 1'b1, b);
    endtask

    task automatic set_pix(input int v);
        for (int i = 0; i < 25; i++) pix[i] = 8'(v);
    endtask

    task automatic set_pix_rand();
        for (int i = 0; i < 25; i++) pix[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int w[25];

        bus.valid_in     = 1'b0;
        bus.w_load_start = 1'b0;
        bus.w_load_en    = 1'b0;
        bus.w_data       = '0;
        bus.data_in      = '0;
        for (int i = 0; i < 25; i++) kw[i] = 0;
        kb = 0;
        set_pix(0);
        model_reset();

        #3;
        check("rst_data_out", bus.data_out, 0);
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_w_ready", bus.w_ready, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Windows before any kernel and during loading are dropped.
        set_pix(16);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 25; i++) w[i] = 1;
        load(w, 0, 1'b1);
        idle(5);

        // All-ones kernel, pixels 16: single-cycle result of 25.
        step(1'b1, 1'b0, 1'b0, 0);
        idle(6);

        // Bias 2, zero window, then 30 back-to-back ramp windows.
        load(w, 2, 1'b0);
        set_pix(0);
        step(1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 30; k++) begin
            set_pix(k);
            step(1'b1, 1'b0, 1'b0, 0);
        end
        idle(5);

        // Positive and negative saturation.
        for (int i = 0; i < 25; i++) w[i] = 127;
        load(w, 0, 1'b0);
        set_pix(255);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(5);
        for (int i = 0; i < 25; i++) w[i] = -128;
        load(w, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(5);

        // Reload two cycles after an accepted window discards it.
        for (int i = 0; i < 25; i++) w[i] = 1;
        load(w, 0, 1'b0);
        set_pix(16);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 1'b1, 0);
        idle(5);

        // Surplus beats after the bias are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, -1);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(5);

        // Start coincident with a beat: that beat is discarded.
        step(1'b0, 1'b1, 1'b1, -1);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, i - 12);
        step(1'b0, 1'b0, 1'b1, 3);
        set_pix_rand();
        step(1'b1, 1'b0, 1'b0, 0);
        idle(5);

        // Random kernel, random stream with gaps.
        for (int i = 0; i < 25; i++) w[i] = int'($urandom_range(0, 255)) - 128;
        load(w, int'($urandom_range(0, 255)) - 128, 1'b0);
        for (int n = 0; n < 40; n++) begin
            set_pix_rand();
            step(($urandom_range(0, 9) < 7), 1'b0, 1'b0, 0);
        end

        // Asynchronous reset with results in flight.
        for (int n = 0; n < 3; n++) begin
            set_pix_rand();
            step(1'b1, 1'b0, 1'b0, 0);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_data_out", bus.data_out, 0);
        check("arst_valid_out", bus.valid_out, 0);
        check("arst_w_ready", bus.w_ready, 0);
        model_reset();
        #2 rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            set_pix_rand();
            step(1'b1, 1'b0, 1'b0, 0);
        end

        // Full reload after reset, then another random stream.
        for (int i = 0; i < 25; i++) w[i] = int'($urandom_range(0, 255)) - 128;
        load(w, int'($urandom_range(0, 255)) - 128, 1'b1);
        for (int n = 0; n < 30; n++) begin
            set_pix_rand();
            step(($urandom_range(0, 9) < 8), 1'b0, 1'b0, 0);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
